// File: rtl/fractal_pkg.sv
// Shared types and constants for the escape-time fractal engine.
package fractal_pkg;

    typedef enum logic [2:0] {IDLE, ISSUE0, ISSUE1, ISSUE2, WAIT, UPDATE} state_t;

    typedef enum logic {MODE_MANDEL, MODE_JULIA} mode_t;

    // Identifies which product is travelling through the multiplier pipe.
    typedef enum logic [1:0] {TAG_XX, TAG_YY, TAG_XY} tag_t;

    // 4.0 in fixed point with fbits fractional bits; callers slice to WIDTH+1 bits.
    function automatic logic [63:0] escape_limit(input int unsigned fbits);
        return 64'd4 << fbits;
    endfunction

endpackage

// File: rtl/fixed_mul_pipe.sv
// Pipelined signed fixed-point multiplier with floor rounding, overflow flag and a
// valid/tag shift register that a flush empties.
module fixed_mul_pipe #(
    parameter int WIDTH = 25,
    parameter int FBITS = 21,
    parameter int LAT   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [1:0]              in_tag,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic                    out_valid,
    output logic [1:0]              out_tag,
    output logic signed [WIDTH-1:0] p,
    output logic                    ovf
);

    localparam int PW = 2 * WIDTH;

    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   shifted;
    logic [PW-WIDTH:0]      hi;
    logic                   ovf_c;

    logic [LAT-1:0]         vld_q;
    logic [LAT-1:0]         ovf_q;
    logic [1:0]             tag_q [LAT];
    logic [WIDTH-1:0]       p_q   [LAT];

    assign prod    = a * b;
    assign shifted = prod >>> FBITS;
    // Product fits only if everything above the result's sign bit repeats it.
    assign hi      = shifted[PW-1:WIDTH-1];
    assign ovf_c   = (hi != '0) && (hi != '1);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= in_valid;
            for (int i = 1; i < LAT; i++) vld_q[i] <= vld_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        tag_q[0] <= in_tag;
        p_q[0]   <= shifted[WIDTH-1:0];
        ovf_q[0] <= ovf_c;
        for (int i = 1; i < LAT; i++) begin
            tag_q[i] <= tag_q[i-1];
            p_q[i]   <= p_q[i-1];
            ovf_q[i] <= ovf_q[i-1];
        end
    end

    assign out_valid = vld_q[LAT-1];
    assign out_tag   = tag_q[LAT-1];
    assign p         = p_q[LAT-1];
    assign ovf       = ovf_q[LAT-1];

endmodule

// File: rtl/fractal_iter.sv
// Escape-time engine: iterates z = z^2 + c in signed fixed point for Mandelbrot or
// Julia points, reporting iteration count and whether the orbit escaped.
module fractal_iter
    import fractal_pkg::*;
#(
    parameter int WIDTH   = 25,
    parameter int IBITS   = 4,
    parameter int ITERW   = 8,
    parameter int MUL_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    julia,
    input  logic signed [WIDTH-1:0] re,
    input  logic signed [WIDTH-1:0] im,
    input  logic signed [WIDTH-1:0] jre,
    input  logic signed [WIDTH-1:0] jim,
    input  logic [ITERW-1:0]        max_iter,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic [ITERW-1:0]        iter,
    output logic                    escaped
);

    localparam int FBITS = WIDTH - IBITS;
    localparam int WCW   = $clog2(MUL_LAT + 1);
    localparam logic [63:0]           LIMIT_W   = escape_limit(FBITS);
    localparam logic signed [WIDTH:0] LIMIT     = LIMIT_W[WIDTH:0];
    localparam logic [WCW-1:0]        WAIT_LAST = WCW'(MUL_LAT - 1);

    state_t                   state;
    mode_t                    start_mode;
    logic signed [WIDTH-1:0]  zx, zy, cr, ci;
    logic signed [WIDTH-1:0]  x2, y2, xy;
    logic [2:0]               p_ovf;
    logic                     z_ovf;
    logic [ITERW-1:0]         max_q;
    logic [WCW-1:0]           wait_cnt;

    logic                     mul_in_valid;
    logic [1:0]               mul_in_tag;
    logic signed [WIDTH-1:0]  mul_a, mul_b;
    logic                     mul_valid;
    logic [1:0]               mul_tag;
    logic signed [WIDTH-1:0]  mul_p;
    logic                     mul_ovf;

    logic signed [WIDTH:0]    mag;
    logic signed [WIDTH+1:0]  nx, ny;
    logic                     nx_ovf, ny_ovf;
    logic                     esc;

    assign start_mode = julia ? MODE_JULIA : MODE_MANDEL;

    always_comb begin
        mul_in_valid = 1'b0;
        mul_in_tag   = TAG_XX;
        mul_a        = zx;
        mul_b        = zx;
        unique case (state)
            ISSUE0: mul_in_valid = 1'b1;
            ISSUE1: begin
                mul_in_valid = 1'b1;
                mul_in_tag   = TAG_YY;
                mul_a        = zy;
                mul_b        = zy;
            end
            ISSUE2: begin
                mul_in_valid = 1'b1;
                mul_in_tag   = TAG_XY;
                mul_b        = zy;
            end
            default: ;
        endcase
    end

    fixed_mul_pipe #(
        .WIDTH (WIDTH),
        .FBITS (FBITS),
        .LAT   (MUL_LAT)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .flush     (abort),
        .in_valid  (mul_in_valid),
        .in_tag    (mul_in_tag),
        .a         (mul_a),
        .b         (mul_b),
        .out_valid (mul_valid),
        .out_tag   (mul_tag),
        .p         (mul_p),
        .ovf       (mul_ovf)
    );

    // Magnitude and next z are computed wide so nothing wraps before the checks.
    assign mag    = {x2[WIDTH-1], x2} + {y2[WIDTH-1], y2};
    assign nx     = {{2{x2[WIDTH-1]}}, x2} - {{2{y2[WIDTH-1]}}, y2} + {{2{cr[WIDTH-1]}}, cr};
    assign ny     = {xy[WIDTH-1], xy, 1'b0} + {{2{ci[WIDTH-1]}}, ci};
    assign nx_ovf = (nx[WIDTH+1:WIDTH-1] != 3'b000) && (nx[WIDTH+1:WIDTH-1] != 3'b111);
    assign ny_ovf = (ny[WIDTH+1:WIDTH-1] != 3'b000) && (ny[WIDTH+1:WIDTH-1] != 3'b111);
    assign esc    = (mag > LIMIT) || (|p_ovf) || z_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            iter     <= '0;
            escaped  <= 1'b0;
            zx       <= '0;
            zy       <= '0;
            cr       <= '0;
            ci       <= '0;
            x2       <= '0;
            y2       <= '0;
            xy       <= '0;
            p_ovf    <= '0;
            z_ovf    <= 1'b0;
            max_q    <= '0;
            wait_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (abort && state != IDLE) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            state   <= ISSUE0;
                            busy    <= 1'b1;
                            iter    <= '0;
                            escaped <= 1'b0;
                            z_ovf   <= 1'b0;
                            max_q   <= max_iter;
                            if (start_mode == MODE_JULIA) begin
                                zx <= re;
                                zy <= im;
                                cr <= jre;
                                ci <= jim;
                            end else begin
                                zx <= '0;
                                zy <= '0;
                                cr <= re;
                                ci <= im;
                            end
                        end
                    end
                    ISSUE0: state <= ISSUE1;
                    ISSUE1: state <= ISSUE2;
                    ISSUE2: begin
                        state    <= WAIT;
                        wait_cnt <= '0;
                    end
                    WAIT: begin
                        if (wait_cnt == WAIT_LAST) state <= UPDATE;
                        else wait_cnt <= wait_cnt + WCW'(1);
                    end
                    UPDATE: begin
                        if (esc || iter == max_q) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            escaped <= esc;
                        end else begin
                            state <= ISSUE0;
                            zx    <= nx[WIDTH-1:0];
                            zy    <= ny[WIDTH-1:0];
                            z_ovf <= z_ovf | nx_ovf | ny_ovf;
                            iter  <= iter + ITERW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            if (mul_valid && !abort) begin
                unique case (tag_t'(mul_tag))
                    TAG_XX: begin
                        x2       <= mul_p;
                        p_ovf[0] <= mul_ovf;
                    end
                    TAG_YY: begin
                        y2       <= mul_p;
                        p_ovf[1] <= mul_ovf;
                    end
                    TAG_XY: begin
                        xy       <= mul_p;
                        p_ovf[2] <= mul_ovf;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fractal_iter.sv
// Bench for fractal_iter: directed corner points, control cases and random points
// compared against an arithmetic escape-time model.
module tb_fractal_iter;

    localparam int WIDTH   = 25;
    localparam int IBITS   = 4;
    localparam int ITERW   = 8;
    localparam int MUL_LAT = 2;
    localparam int FB      = WIDTH - IBITS;
    localparam int PER     = MUL_LAT + 4;
    localparam longint ONE  = 64'sd1 << FB;
    localparam longint HALF = 64'sd1 << (WIDTH - 1);

    logic                    clk = 1'b0;
    logic                    rst, start, julia, abort;
    logic signed [WIDTH-1:0] re, im, jre, jim;
    logic [ITERW-1:0]        max_iter;
    logic                    busy, done, escaped;
    logic [ITERW-1:0]        iter;

    int checks = 0;
    int errors = 0;

    fractal_iter #(
        .WIDTH   (WIDTH),
        .IBITS   (IBITS),
        .ITERW   (ITERW),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .julia    (julia),
        .re       (re),
        .im       (im),
        .jre      (jre),
        .jim      (jim),
        .max_iter (max_iter),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .iter     (iter),
        .escaped  (escaped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic bit out_of_range(input longint v);
        return (v < -HALF) || (v > HALF - 1);
    endfunction

    function automatic longint wrap(input longint v);
        longint t = v & ((HALF << 1) - 1);
        if (t >= HALF) t -= (HALF << 1);
        return t;
    endfunction

    // Escape-time reference: iterate with exact integers, floor the products.
    function automatic void model(input bit jl, input longint r, input longint i,
                                  input longint jr, input longint ji, input int maxit,
                                  output int k, output bit esc);
        longint zx, zy, cr, ci, x2, y2, xy, nx, ny;
        bit zovf = 0;
        int it = 0;
        zx = jl ? r : 0;
        zy = jl ? i : 0;
        cr = jl ? jr : r;
        ci = jl ? ji : i;
        forever begin
            x2 = (zx * zx) >>> FB;
            y2 = (zy * zy) >>> FB;
            xy = (zx * zy) >>> FB;
            if (out_of_range(x2) || out_of_range(y2) || out_of_range(xy) || zovf ||
                (x2 + y2 > 4 * ONE)) begin
                k = it; esc = 1; return;
            end
            if (it == maxit) begin
                k = it; esc = 0; return;
            end
            nx = x2 - y2 + cr;
            ny = 2 * xy + ci;
            if (out_of_range(nx) || out_of_range(ny)) zovf = 1;
            zx = wrap(nx);
            zy = wrap(ny);
            it++;
        end
    endfunction

    task automatic launch(input bit jl, input longint r, input longint i,
                          input longint jr, input longint ji, input int maxit);
        @(negedge clk);
        julia    = jl;
        re       = WIDTH'(r);
        im       = WIDTH'(i);
        jre      = WIDTH'(jr);
        jim      = WIDTH'(ji);
        max_iter = ITERW'(maxit);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Returns the cycle offset (relative to the start cycle) at which done is seen.
    task automatic wait_done(input int from, input int bound, output int lat);
        int c = from;
        while (done !== 1'b1 && c < bound) begin
            @(negedge clk);
            c++;
        end
        lat = c;
    endtask

    task automatic run_point(input string tag, input bit jl, input longint r, input longint i,
                             input longint jr, input longint ji, input int maxit,
                             input int exp_k, input bit exp_esc);
        int lat;
        int exp_lat = (exp_k + 1) * PER + 1;
        launch(jl, r, i, jr, ji, maxit);
        check({tag, "_busy"}, busy, 1);
        wait_done(1, exp_lat + 12, lat);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_iter"}, iter, exp_k);
        check({tag, "_escaped"}, escaped, exp_esc);
        check({tag, "_idle"}, busy, 0);
        @(negedge clk);
        check({tag, "_pulse"}, done, 0);
        check({tag, "_hold"}, iter, exp_k);
        if (lat != exp_lat) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
    endtask

    initial begin
        int lat, dones, k;
        bit esc, jl;
        longint r, i, jr, ji;
        int mi;

        rst = 1'b1; start = 1'b0; julia = 1'b0; abort = 1'b0;
        re = '0; im = '0; jre = '0; jim = '0; max_iter = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_iter", iter, 0);
        check("rst_escaped", escaped, 0);

        run_point("origin", 0, 0, 0, 0, 0, 255, 255, 0);
        run_point("c_2", 0, 2 * ONE, 0, 0, 0, 255, 2, 1);
        run_point("c_m2", 0, -2 * ONE, 0, 0, 0, 255, 255, 0);
        run_point("julia_3", 1, 3 * ONE, 0, 0, 0, 255, 0, 1);
        run_point("c_7p5", 0, 15 * ONE / 2, 15 * ONE / 2, 0, 0, 255, 1, 1);
        run_point("maxit0", 0, 0, 0, 0, 0, 0, 0, 0);

        // A start pulse while busy must not disturb the running point.
        launch(0, 0, 0, 0, 0, 10);
        repeat (9) @(negedge clk);
        julia = 1'b1; re = WIDTH'(3 * ONE); max_iter = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(11, 90, lat);
        check("busy_start_latency", lat, 11 * PER + 1);
        check("busy_start_iter", iter, 10);
        check("busy_start_escaped", escaped, 0);
        @(negedge clk);
        if (busy) begin rst = 1'b1; @(negedge clk); rst = 1'b0; end

        // Abort at cycle 20: three updates completed, then idle with no done.
        launch(0, 0, 0, 0, 0, 255);
        repeat (19) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_iter", iter, 3);
        check("abort_escaped", escaped, 0);
        dones = 0;
        for (int n = 0; n < 30; n++) begin
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        check("abort_no_done", dones, 0);

        abort = 1'b1;
        repeat (2) @(negedge clk);
        abort = 1'b0;
        check("idle_abort_busy", busy, 0);
        check("idle_abort_iter", iter, 3);

        // Synchronous reset mid-run clears everything on the next cycle.
        launch(0, 0, 0, 0, 0, 255);
        repeat (29) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_iter", iter, 0);
        check("midrst_escaped", escaped, 0);
        rst = 1'b0;

        for (int n = 0; n < 24; n++) begin
            jl = 1'($urandom_range(0, 1));
            r  = longint'(int'($urandom_range(0, 10485760)) - 5242880);
            i  = longint'(int'($urandom_range(0, 10485760)) - 5242880);
            jr = longint'(int'($urandom_range(0, 4194304)) - 2097152);
            ji = longint'(int'($urandom_range(0, 4194304)) - 2097152);
            mi = int'($urandom_range(0, 48));
            model(jl, r, i, jr, ji, mi, k, esc);
            run_point($sformatf("rnd%0d", n), jl, r, i, jr, ji, mi, k, esc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
